mem_req_arbiter: RTL and testbench
==================================

Name: mem_req_arbiter

Overview:
- Shares one 4B memory port between two requesters: req0 (instruction fetch) and req1 (data access).
- Sits between the processor's imem/dmem request/response streams and a single-ported memory or cache.
- Round-robin arbitration on requests.
- Records grant order plus each request's original opaque field in an order queue. The memory returns responses in order, so each response is routed back by the queue head and its opaque field is restored.

Parameters:
p_max_outstanding, 4, depth of the order queue and maximum number of in-flight requests (power of two, at least 2)

Ports:
clk  input  1  clock; all state updates on rising edge
reset  input  1  asynchronous, active-low reset
req0_msg  input  mem_req_4B_t  requester 0 request
req0_val  input  1  requester 0 request valid
req0_rdy  output  1  requester 0 request ready
req1_msg  input  mem_req_4B_t  requester 1 request
req1_val  input  1  requester 1 request valid
req1_rdy  output  1  requester 1 request ready
resp0_msg  output  mem_resp_4B_t  response routed to requester 0
resp0_val  output  1  response valid, requester 0
resp0_rdy  input  1  response ready, requester 0
resp1_msg  output  mem_resp_4B_t  response routed to requester 1
resp1_val  output  1  response valid, requester 1
resp1_rdy  input  1  response ready, requester 1
mem_req_msg  output  mem_req_4B_t  shared memory request
mem_req_val  output  1  shared memory request valid
mem_req_rdy  input  1  shared memory request ready
mem_resp_msg  input  mem_resp_4B_t  shared memory response
mem_resp_val  input  1  shared memory response valid
mem_resp_rdy  output  1  shared memory response ready
num_outstanding  output  $clog2(p_max_outstanding)+1  current number of entries in the order queue

Behaviour:
- Reset (reset low, asynchronous): priority pointer = req0; order queue empty; num_outstanding = 0. All val/rdy outputs must be 0 while the queue is empty and reset is asserted.
- Arbitration is combinational (zero latency), round-robin.
  - Winner = the requester with val asserted; if both are asserted, the one the priority pointer selects.
  - mem_req_val = (req0_val | req1_val) & !full.
  - mem_req_msg = winner's msg with opaque replaced by {7'b0, winner_id}.
  - reqN_rdy = (winner==N) & mem_req_rdy & !full. The loser's rdy = 0.
- Request fire (mem_req_val & mem_req_rdy):
  - push {winner_id, original opaque} into the order queue;
  - priority pointer moves to the non-winner.
  - The pointer is unchanged when no fire occurs. A held request keeps priority until it fires, so no starvation.
- Full: no request accepted, even if a response pops in the same cycle. This keeps response handshakes off the request ready path.
- Response routing (combinational):
  - head id H selects the destination.
  - respH_val = mem_resp_val & !empty; the other resp_val = 0.
  - respH_msg = mem_resp_msg with opaque restored from the head entry.
  - mem_resp_rdy = !empty & respH_rdy.
- Response fire pops the head.
- mem_resp_val while empty: mem_resp_rdy = 0. The response is held and never dropped or routed.
- Simultaneous push and pop with the queue not full: num_outstanding is unchanged; head and tail both advance.
- Queue pointers wrap modulo p_max_outstanding. num_outstanding saturates at p_max_outstanding by construction, because push is blocked when full.
- Reset asserted mid-transaction: all in-flight bookkeeping is discarded. The surrounding system must reset the memory together with the arbiter.

Optional Feature:
- Macro: MEM_REQ_ARBITER_PERF_CNT_EN.
- Defined: adds outputs stall_cnt0 and stall_cnt1 (32 bits each).
  - stall_cntN increments each cycle reqN_val & !reqN_rdy.
  - Reset value 0; wraps at 2^32.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Decomposition:
- Shared package mem_arb_pkg holds:
  - typedef arb_id_t (1 bit);
  - typedef arb_order_entry_t {arb_id_t id; logic [7:0] opaque};
  - constants ARB_ID_REQ0 = 0 and ARB_ID_REQ1 = 1.
- One sub-module, mem_arb_order_queue: a normal (non-bypass) FIFO of arb_order_entry_t.
  - Depth p_max_outstanding.
  - Outputs full, empty, head and count.
  - Uses the same asynchronous active-low reset.

Test Plan:
1. Reset low, then high; only req0_val=1 with addr 0x200, opaque 0x5A, mem_req_rdy=1 -> same cycle mem_req_val=1, req0_rdy=1, mem_req_msg.opaque=0x00. Response data 0xDEADBEEF -> resp0_val=1, resp0_msg.opaque=0x5A, resp1_val=0.
2. Both requesters valid every cycle, mem_req_rdy=1, responses drained -> grants alternate 0,1,0,1 over 4 cycles; each response returns to its issuer in order.
3. Memory never responds; req0 streams requests -> exactly 4 accepted; num_outstanding=4; req0_rdy stays 0 thereafter. One response pops -> num_outstanding=3; next cycle a request is accepted.
4. Order queue holds [1,0]; resp1_rdy=0 for 3 cycles -> mem_resp_rdy=0 for 3 cycles and resp0_val=0; then resp1_rdy=1 -> pop; the second response goes to req0.
5. mem_resp_val=1 while empty -> mem_resp_rdy=0, both resp_val=0. Reset pulsed low mid-stream with 3 outstanding -> num_outstanding=0 immediately, before the next edge; priority pointer back to req0.
6. With MEM_REQ_ARBITER_PERF_CNT_EN defined: both valid for 10 cycles, mem_req_rdy=1 -> stall_cnt0=5, stall_cnt1=5.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port memory request arbiter.
// Request/response message layouts, requester ids and the order-queue entry.
package mem_arb_pkg;

    typedef logic [0:0] arb_id_t;

    localparam arb_id_t ARB_ID_REQ0 = 1'b0;
    localparam arb_id_t ARB_ID_REQ1 = 1'b1;

    typedef struct packed {
        arb_id_t    id;
        logic [7:0] opaque;
    } arb_order_entry_t;

    typedef struct packed {
        logic [2:0]  msg_type;
        logic [7:0]  opaque;
        logic [31:0] addr;
        logic [1:0]  len;
        logic [31:0] data;
    } mem_req_4B_t;

    typedef struct packed {
        logic [2:0]  msg_type;
        logic [7:0]  opaque;
        logic [1:0]  test;
        logic [1:0]  len;
        logic [31:0] data;
    } mem_resp_4B_t;

    // The opaque field sent to memory carries only the requester id
    function automatic logic [7:0] id_to_opaque(arb_id_t id);
        return {7'b0, id};
    endfunction

endpackage

// File: rtl/mem_req_arbiter_if.sv
// Handshake bundle for the arbiter: two requester streams, two response
// streams and the shared memory port. The slave modport is the arbiter's view.
interface mem_req_arbiter_if;
    import mem_arb_pkg::*;

    mem_req_4B_t  req0_msg;
    logic         req0_val;
    logic         req0_rdy;
    mem_req_4B_t  req1_msg;
    logic         req1_val;
    logic         req1_rdy;

    mem_resp_4B_t resp0_msg;
    logic         resp0_val;
    logic         resp0_rdy;
    mem_resp_4B_t resp1_msg;
    logic         resp1_val;
    logic         resp1_rdy;

    mem_req_4B_t  mem_req_msg;
    logic         mem_req_val;
    logic         mem_req_rdy;
    mem_resp_4B_t mem_resp_msg;
    logic         mem_resp_val;
    logic         mem_resp_rdy;

    modport slave (
        input  req0_msg, req0_val, output req0_rdy,
        input  req1_msg, req1_val, output req1_rdy,
        output resp0_msg, resp0_val, input resp0_rdy,
        output resp1_msg, resp1_val, input resp1_rdy,
        output mem_req_msg, mem_req_val, input mem_req_rdy,
        input  mem_resp_msg, mem_resp_val, output mem_resp_rdy
    );

    modport master (
        output req0_msg, req0_val, input req0_rdy,
        output req1_msg, req1_val, input req1_rdy,
        input  resp0_msg, resp0_val, output resp0_rdy,
        input  resp1_msg, resp1_val, output resp1_rdy,
        input  mem_req_msg, mem_req_val, output mem_req_rdy,
        output mem_resp_msg, mem_resp_val, input mem_resp_rdy
    );

endinterface

// File: rtl/mem_arb_order_queue.sv
// Plain (non-bypass) FIFO recording which requester owns each in-flight
// memory request together with that request's original opaque field.
module mem_arb_order_queue
    import mem_arb_pkg::*;
#(
    parameter int p_depth = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  arb_order_entry_t       push_data,
    input  logic                   pop,
    output logic                   full,
    output logic                   empty,
    output arb_order_entry_t       head,
    output logic [$clog2(p_depth):0] count
);

    localparam int AW = $clog2(p_depth);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(p_depth);

    arb_order_entry_t storage [p_depth];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign head    = storage[rd_ptr];

    // Entry storage needs no reset; occupancy is tracked by count
    always_ff @(posedge clk) begin
        if (do_push) begin
            storage[wr_ptr] <= push_data;
        end
    end

    // Pointers wrap naturally since the depth is a power of two
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/mem_req_arbiter.sv
// Round-robin arbiter sharing one 4B memory port between instruction fetch
// (req0) and data access (req1). Grant order is queued so in-order memory
// responses are routed back to their issuer with the opaque field restored.
// Optional stall counters: define MEM_REQ_ARBITER_PERF_CNT_EN.
module mem_req_arbiter
    import mem_arb_pkg::*;
#(
    parameter int p_max_outstanding = 4
) (
    input  logic                             clk,
    input  logic                             reset,
    mem_req_arbiter_if.slave                 bus,
`ifdef MEM_REQ_ARBITER_PERF_CNT_EN
    output logic [31:0]                      stall_cnt0,
    output logic [31:0]                      stall_cnt1,
`endif
    output logic [$clog2(p_max_outstanding):0] num_outstanding
);

    logic             q_full;
    logic             q_empty;
    logic             q_push;
    logic             q_pop;
    arb_order_entry_t q_head;
    arb_order_entry_t q_push_entry;
    arb_id_t          prio_ptr;
    arb_id_t          winner;
    logic             any_val;
    logic             accept_ok;
    logic             head_rdy;
    mem_req_4B_t      win_msg;
    mem_resp_4B_t     resp_restored;

    // Requests are only offered while out of reset and the queue has room
    assign accept_ok = reset & ~q_full;

    // Winner is the sole valid requester, or the pointer's choice when both ask
    always_comb begin
        any_val = bus.req0_val | bus.req1_val;
        if (bus.req0_val && bus.req1_val) begin
            winner = prio_ptr;
        end else if (bus.req1_val) begin
            winner = ARB_ID_REQ1;
        end else begin
            winner = ARB_ID_REQ0;
        end
        win_msg = (winner == ARB_ID_REQ1) ? bus.req1_msg : bus.req0_msg;
    end

    // Forward the winner to memory with its id in place of the opaque field
    always_comb begin
        bus.mem_req_val        = any_val & accept_ok;
        bus.mem_req_msg        = win_msg;
        bus.mem_req_msg.opaque = id_to_opaque(winner);
        bus.req0_rdy           = (winner == ARB_ID_REQ0) & bus.mem_req_rdy & accept_ok;
        bus.req1_rdy           = (winner == ARB_ID_REQ1) & bus.mem_req_rdy & accept_ok;
        q_push                 = bus.mem_req_val & bus.mem_req_rdy;
        q_push_entry.id        = winner;
        q_push_entry.opaque    = win_msg.opaque;
    end

    // Route each memory response to the requester at the head of the queue
    always_comb begin
        head_rdy             = (q_head.id == ARB_ID_REQ1) ? bus.resp1_rdy : bus.resp0_rdy;
        resp_restored        = bus.mem_resp_msg;
        resp_restored.opaque = q_head.opaque;
        bus.resp0_msg        = resp_restored;
        bus.resp1_msg        = resp_restored;
        bus.resp0_val        = bus.mem_resp_val & ~q_empty & (q_head.id == ARB_ID_REQ0);
        bus.resp1_val        = bus.mem_resp_val & ~q_empty & (q_head.id == ARB_ID_REQ1);
        bus.mem_resp_rdy     = ~q_empty & head_rdy;
        q_pop                = bus.mem_resp_val & bus.mem_resp_rdy;
    end

    // Priority passes to the other requester only when a request is accepted
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prio_ptr <= ARB_ID_REQ0;
        end else if (q_push) begin
            prio_ptr <= ~winner;
        end
    end

    mem_arb_order_queue #(
        .p_depth (p_max_outstanding)
    ) u_order_q (
        .clk       (clk),
        .reset     (reset),
        .push      (q_push),
        .push_data (q_push_entry),
        .pop       (q_pop),
        .full      (q_full),
        .empty     (q_empty),
        .head      (q_head),
        .count     (num_outstanding)
    );

`ifdef MEM_REQ_ARBITER_PERF_CNT_EN
    // Count cycles each requester holds a valid request that is not taken
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt0 <= '0;
            stall_cnt1 <= '0;
        end else begin
            if (bus.req0_val && !bus.req0_rdy) begin
                stall_cnt0 <= stall_cnt0 + 32'd1;
            end
            if (bus.req1_val && !bus.req1_rdy) begin
                stall_cnt1 <= stall_cnt1 + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Testbench for mem_req_arbiter: directed vectors with literal expectations,
// plus a queue-based reference model compared against the DUT every cycle.
// Stall counters are checked when MEM_REQ_ARBITER_PERF_CNT_EN is defined.
module tb_mem_req_arbiter;
    import mem_arb_pkg::*;

    localparam int D = 4;

    logic clk = 1'b0;
    logic reset;
    logic [$clog2(D):0] num_outstanding;
`ifdef MEM_REQ_ARBITER_PERF_CNT_EN
    logic [31:0] stall_cnt0;
    logic [31:0] stall_cnt1;
`endif

    mem_req_arbiter_if bus_if();

    mem_req_arbiter #(
        .p_max_outstanding (D)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .bus             (bus_if),
`ifdef MEM_REQ_ARBITER_PERF_CNT_EN
        .stall_cnt0      (stall_cnt0),
        .stall_cnt1      (stall_cnt1),
`endif
        .num_outstanding (num_outstanding)
    );

    // Free-running clock, 10 time units per cycle
    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    task automatic check_output(string name, logic [127:0] act, logic [127:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic mem_req_4B_t mk_req(logic [31:0] addr, logic [7:0] op);
        mem_req_4B_t m;
        m.msg_type = 3'd0;
        m.opaque   = op;
        m.addr     = addr;
        m.len      = 2'd0;
        m.data     = addr ^ 32'hA5A5_0000;
        return m;
    endfunction

    function automatic mem_resp_4B_t mk_resp(logic [31:0] data, logic [7:0] op);
        mem_resp_4B_t m;
        m.msg_type = 3'd0;
        m.opaque   = op;
        m.test     = 2'd0;
        m.len      = 2'd0;
        m.data     = data;
        return m;
    endfunction

    // Reference model state: outstanding owners/opaques in grant order
    arb_id_t    m_id_q[$];
    logic [7:0] m_op_q[$];
    arb_id_t    m_ptr = ARB_ID_REQ0;
    bit         m_push = 1'b0;
    bit         m_pop  = 1'b0;
    arb_id_t    m_win  = ARB_ID_REQ0;
    logic [7:0] m_win_op = 8'h00;

    // Compare every DUT output against the model mid-cycle, then note transfers
    always @(negedge clk) begin : cmp
        int           n;
        bit           running;
        bit           full;
        bit           empty;
        bit           any;
        arb_id_t      w;
        arb_id_t      h;
        mem_req_4B_t  exp_req;
        mem_resp_4B_t exp_resp;
        bit           exp_mqv, exp_r0r, exp_r1r, exp_rv0, exp_rv1, exp_mrr;

        n       = m_id_q.size();
        running = (reset === 1'b1);
        full    = (n == D);
        empty   = (n == 0);
        any     = bus_if.req0_val | bus_if.req1_val;
        if (bus_if.req0_val && bus_if.req1_val) w = m_ptr;
        else w = bus_if.req1_val ? ARB_ID_REQ1 : ARB_ID_REQ0;
        h       = empty ? ARB_ID_REQ0 : m_id_q[0];

        exp_mqv = running && any && !full;
        exp_r0r = running && !full && bus_if.mem_req_rdy && (w == ARB_ID_REQ0);
        exp_r1r = running && !full && bus_if.mem_req_rdy && (w == ARB_ID_REQ1);
        exp_req = (w == ARB_ID_REQ1) ? bus_if.req1_msg : bus_if.req0_msg;
        exp_req.opaque = {7'b0, w};

        exp_rv0 = !empty && bus_if.mem_resp_val && (h == ARB_ID_REQ0);
        exp_rv1 = !empty && bus_if.mem_resp_val && (h == ARB_ID_REQ1);
        exp_mrr = !empty && ((h == ARB_ID_REQ1) ? bus_if.resp1_rdy : bus_if.resp0_rdy);
        exp_resp = bus_if.mem_resp_msg;
        exp_resp.opaque = empty ? 8'h00 : m_op_q[0];

        check_output("mdl_num_outstanding", num_outstanding, n);
        check_output("mdl_mem_req_val", bus_if.mem_req_val, exp_mqv);
        check_output("mdl_req0_rdy", bus_if.req0_rdy, exp_r0r);
        check_output("mdl_req1_rdy", bus_if.req1_rdy, exp_r1r);
        if (exp_mqv) check_output("mdl_mem_req_msg", bus_if.mem_req_msg, exp_req);
        check_output("mdl_resp0_val", bus_if.resp0_val, exp_rv0);
        check_output("mdl_resp1_val", bus_if.resp1_val, exp_rv1);
        check_output("mdl_mem_resp_rdy", bus_if.mem_resp_rdy, exp_mrr);
        if (exp_rv0) check_output("mdl_resp0_msg", bus_if.resp0_msg, exp_resp);
        if (exp_rv1) check_output("mdl_resp1_msg", bus_if.resp1_msg, exp_resp);

        m_push   = exp_mqv && bus_if.mem_req_rdy;
        m_win    = w;
        m_win_op = (w == ARB_ID_REQ1) ? bus_if.req1_msg.opaque : bus_if.req0_msg.opaque;
        m_pop    = bus_if.mem_resp_val && exp_mrr;
    end

    // Advance the model on each edge; reset discards all outstanding entries
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_id_q.delete();
            m_op_q.delete();
            m_ptr = ARB_ID_REQ0;
        end else begin
            if (m_pop) begin
                void'(m_id_q.pop_front());
                void'(m_op_q.pop_front());
            end
            if (m_push) begin
                m_id_q.push_back(m_win);
                m_op_q.push_back(m_win_op);
                m_ptr = ~m_win;
            end
        end
    end

    task automatic apply_stimulus_idle();
        bus_if.req0_val     = 1'b0;
        bus_if.req0_msg     = '0;
        bus_if.req1_val     = 1'b0;
        bus_if.req1_msg     = '0;
        bus_if.mem_req_rdy  = 1'b0;
        bus_if.mem_resp_val = 1'b0;
        bus_if.mem_resp_msg = '0;
        bus_if.resp0_rdy    = 1'b0;
        bus_if.resp1_rdy    = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        tick();
        reset = 1'b0;
        apply_stimulus_idle();
        tick();
        reset = 1'b1;
    endtask

    // Bound the whole run so a stuck DUT still yields a verdict
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached, vectors=%0d", vectors);
        $fatal(1, "[TB] timeout");
    end

    initial begin
        int accepted;

        reset = 1'b0;
        apply_stimulus_idle();
        bus_if.req0_val     = 1'b1;
        bus_if.req0_msg     = mk_req(32'h100, 8'h33);
        bus_if.mem_req_rdy  = 1'b1;
        bus_if.mem_resp_val = 1'b1;
        bus_if.resp0_rdy    = 1'b1;
        bus_if.resp1_rdy    = 1'b1;
        @(negedge clk);
        check_output("rst_num_outstanding", num_outstanding, 0);
        check_output("rst_mem_req_val", bus_if.mem_req_val, 0);
        check_output("rst_req0_rdy", bus_if.req0_rdy, 0);
        check_output("rst_mem_resp_rdy", bus_if.mem_resp_rdy, 0);
        tick();
        apply_stimulus_idle();
        reset = 1'b1;

        $display("[TB] single request from req0");
        bus_if.req0_val    = 1'b1;
        bus_if.req0_msg    = mk_req(32'h200, 8'h5A);
        bus_if.mem_req_rdy = 1'b1;
        @(negedge clk);
        check_output("t1_mem_req_val", bus_if.mem_req_val, 1);
        check_output("t1_req0_rdy", bus_if.req0_rdy, 1);
        check_output("t1_req1_rdy", bus_if.req1_rdy, 0);
        check_output("t1_mem_req_opaque", bus_if.mem_req_msg.opaque, 8'h00);
        check_output("t1_mem_req_addr", bus_if.mem_req_msg.addr, 32'h200);
        tick();
        bus_if.req0_val     = 1'b0;
        bus_if.mem_resp_val = 1'b1;
        bus_if.mem_resp_msg = mk_resp(32'hDEADBEEF, 8'h00);
        bus_if.resp0_rdy    = 1'b1;
        bus_if.resp1_rdy    = 1'b1;
        @(negedge clk);
        check_output("t1_num_outstanding", num_outstanding, 1);
        check_output("t1_resp0_val", bus_if.resp0_val, 1);
        check_output("t1_resp0_opaque", bus_if.resp0_msg.opaque, 8'h5A);
        check_output("t1_resp0_data", bus_if.resp0_msg.data, 32'hDEADBEEF);
        check_output("t1_resp1_val", bus_if.resp1_val, 0);
        tick();
        apply_stimulus_idle();
        @(negedge clk);
        check_output("t1_drained", num_outstanding, 0);

        $display("[TB] both requesters, alternating grants");
        apply_reset();
        bus_if.req0_val     = 1'b1;
        bus_if.req0_msg     = mk_req(32'h300, 8'h11);
        bus_if.req1_val     = 1'b1;
        bus_if.req1_msg     = mk_req(32'h400, 8'h22);
        bus_if.mem_req_rdy  = 1'b1;
        bus_if.mem_resp_val = 1'b1;
        bus_if.mem_resp_msg = mk_resp(32'hCAFE0000, 8'h00);
        bus_if.resp0_rdy    = 1'b1;
        bus_if.resp1_rdy    = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check_output("t2_grant_order", bus_if.mem_req_msg.opaque, 8'(i % 2));
            check_output("t2_req0_rdy", bus_if.req0_rdy, (i % 2) == 0);
            if (i > 0) begin
                check_output("t2_resp_route", {bus_if.resp1_val, bus_if.resp0_val},
                             ((i - 1) % 2) == 1 ? 2'b10 : 2'b01);
            end
            tick();
            bus_if.mem_resp_msg.data = 32'hCAFE0000 + 32'(i + 1);
        end
        bus_if.req0_val = 1'b0;
        bus_if.req1_val = 1'b0;
        @(negedge clk);
        check_output("t2_num_outstanding", num_outstanding, 1);
        check_output("t2_last_resp1_val", bus_if.resp1_val, 1);
        check_output("t2_last_resp1_opaque", bus_if.resp1_msg.opaque, 8'h22);
        tick();
        apply_stimulus_idle();

        $display("[TB] memory stalls, queue fills");
        apply_reset();
        bus_if.req0_val    = 1'b1;
        bus_if.req0_msg    = mk_req(32'h500, 8'h77);
        bus_if.mem_req_rdy = 1'b1;
        accepted = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (bus_if.req0_val && bus_if.req0_rdy) accepted++;
            tick();
        end
        check_output("t3_accepted", accepted, 4);
        @(negedge clk);
        check_output("t3_full_count", num_outstanding, 4);
        check_output("t3_full_req0_rdy", bus_if.req0_rdy, 0);
        tick();
        bus_if.mem_resp_val = 1'b1;
        bus_if.mem_resp_msg = mk_resp(32'h12345678, 8'h00);
        bus_if.resp0_rdy    = 1'b1;
        @(negedge clk);
        check_output("t3_pop_rdy", bus_if.mem_resp_rdy, 1);
        check_output("t3_full_pop_req0_rdy", bus_if.req0_rdy, 0);
        tick();
        bus_if.mem_resp_val = 1'b0;
        @(negedge clk);
        check_output("t3_after_pop_count", num_outstanding, 3);
        check_output("t3_after_pop_req0_rdy", bus_if.req0_rdy, 1);
        tick();
        bus_if.req0_val = 1'b0;
        @(negedge clk);
        check_output("t3_refill_count", num_outstanding, 4);
        tick();
        apply_stimulus_idle();

        $display("[TB] response backpressure");
        apply_reset();
        bus_if.req1_val    = 1'b1;
        bus_if.req1_msg    = mk_req(32'h600, 8'h61);
        bus_if.mem_req_rdy = 1'b1;
        tick();
        bus_if.req1_val = 1'b0;
        bus_if.req0_val = 1'b1;
        bus_if.req0_msg = mk_req(32'h700, 8'h70);
        tick();
        bus_if.req0_val     = 1'b0;
        bus_if.mem_resp_val = 1'b1;
        bus_if.mem_resp_msg = mk_resp(32'h11111111, 8'h00);
        bus_if.resp0_rdy    = 1'b1;
        bus_if.resp1_rdy    = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_output("t4_held_mem_resp_rdy", bus_if.mem_resp_rdy, 0);
            check_output("t4_held_resp0_val", bus_if.resp0_val, 0);
            check_output("t4_held_resp1_val", bus_if.resp1_val, 1);
            tick();
        end
        bus_if.resp1_rdy = 1'b1;
        @(negedge clk);
        check_output("t4_release_rdy", bus_if.mem_resp_rdy, 1);
        check_output("t4_resp1_opaque", bus_if.resp1_msg.opaque, 8'h61);
        tick();
        bus_if.mem_resp_msg.data = 32'h22222222;
        @(negedge clk);
        check_output("t4_second_resp0_val", bus_if.resp0_val, 1);
        check_output("t4_second_resp1_val", bus_if.resp1_val, 0);
        check_output("t4_second_opaque", bus_if.resp0_msg.opaque, 8'h70);
        tick();
        apply_stimulus_idle();

        $display("[TB] response while empty, mid-stream reset");
        apply_reset();
        bus_if.mem_resp_val = 1'b1;
        bus_if.mem_resp_msg = mk_resp(32'h33333333, 8'h44);
        bus_if.resp0_rdy    = 1'b1;
        bus_if.resp1_rdy    = 1'b1;
        @(negedge clk);
        check_output("t5_empty_mem_resp_rdy", bus_if.mem_resp_rdy, 0);
        check_output("t5_empty_resp0_val", bus_if.resp0_val, 0);
        check_output("t5_empty_resp1_val", bus_if.resp1_val, 0);
        tick();
        bus_if.mem_resp_val = 1'b0;
        bus_if.req0_val     = 1'b1;
        bus_if.req0_msg     = mk_req(32'h800, 8'h80);
        bus_if.req1_val     = 1'b1;
        bus_if.req1_msg     = mk_req(32'h900, 8'h90);
        bus_if.mem_req_rdy  = 1'b1;
        repeat (3) tick();
        bus_if.mem_req_rdy = 1'b0;
        @(negedge clk);
        check_output("t5_three_outstanding", num_outstanding, 3);
        check_output("t5_ptr_at_req1", bus_if.mem_req_msg.opaque, 8'h01);
        #2;
        reset = 1'b0;
        #1;
        check_output("t5_async_clear", num_outstanding, 0);
        check_output("t5_rst_mem_req_val", bus_if.mem_req_val, 0);
        check_output("t5_rst_req1_rdy", bus_if.req1_rdy, 0);
        tick();
        reset = 1'b1;
        bus_if.mem_req_rdy = 1'b1;
        @(negedge clk);
        check_output("t5_ptr_back_to_req0", bus_if.mem_req_msg.opaque, 8'h00);
        check_output("t5_req0_rdy", bus_if.req0_rdy, 1);
        tick();
        apply_stimulus_idle();

`ifdef MEM_REQ_ARBITER_PERF_CNT_EN
        $display("[TB] stall counters");
        apply_reset();
        bus_if.req0_val     = 1'b1;
        bus_if.req0_msg     = mk_req(32'hA00, 8'hA0);
        bus_if.req1_val     = 1'b1;
        bus_if.req1_msg     = mk_req(32'hB00, 8'hB0);
        bus_if.mem_req_rdy  = 1'b1;
        bus_if.mem_resp_val = 1'b1;
        bus_if.resp0_rdy    = 1'b1;
        bus_if.resp1_rdy    = 1'b1;
        repeat (10) tick();
        apply_stimulus_idle();
        @(negedge clk);
        check_output("t6_stall_cnt0", stall_cnt0, 32'd5);
        check_output("t6_stall_cnt1", stall_cnt1, 32'd5);
`endif

        tick();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
